// File: rtl/toy_fp_issue_arb_if.sv
// Handshake bundle between the FP issue requesters, the arbiter and the FP unit.
// The slave modport is the arbiter's view; the master modport drives requests and fp_rdy.
interface toy_fp_issue_arb_if #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned PLD_WIDTH = 32,
    parameter int unsigned SRC_W     = $clog2(NUM_REQ),
    parameter int unsigned CNT_W     = 16
);
    logic [NUM_REQ-1:0]           req_vld;
    logic [NUM_REQ-1:0]           req_rdy;
    logic [NUM_REQ*PLD_WIDTH-1:0] req_pld;
    logic                         flush;
    logic                         fp_vld;
    logic                         fp_rdy;
    logic [PLD_WIDTH-1:0]         fp_pld;
    logic [SRC_W-1:0]             fp_src_id;
    logic [CNT_W-1:0]             issue_cnt;

    modport master (
        output req_vld, req_pld, flush, fp_rdy,
        input  req_rdy, fp_vld, fp_pld, fp_src_id, issue_cnt
    );

    modport slave (
        input  req_vld, req_pld, flush, fp_rdy,
        output req_rdy, fp_vld, fp_pld, fp_src_id, issue_cnt
    );
endinterface

// File: rtl/toy_fp_issue_arb.sv
// Round-robin arbiter feeding a one-entry staging register in front of the shared
// non-pipelined FP unit; tags each op with its source id and counts handoffs.
module toy_fp_issue_arb #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned PLD_WIDTH = 32,
    parameter int unsigned SRC_W     = $clog2(NUM_REQ),
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    toy_fp_issue_arb_if.slave  bus
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    stage_e               state_q, state_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]     grant_idx;
    logic [SRC_W-1:0]     src_q;
    logic [PLD_WIDTH-1:0] grant_pld;
    logic [PLD_WIDTH-1:0] pld_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_REQ-1:0]   req_rdy;
    logic                 stage_vld;
    logic                 fp_vld;
    logic                 handoff;
    logic                 can_load;
    logic                 found;
    logic                 accept;

    assign stage_vld = (state_q == ST_FULL);
    assign fp_vld    = stage_vld & ~bus.flush;
    assign handoff   = fp_vld & bus.fp_rdy;
    assign can_load  = ~bus.flush & (~stage_vld | handoff);

    // Wrapped search split into two linear passes: indices >= rr_ptr first, then the rest.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_vld[i] && (i >= 32'(rr_ptr_q))) begin
                found     = 1'b1;
                grant_idx = SRC_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_vld[i] && (i < 32'(rr_ptr_q))) begin
                found     = 1'b1;
                grant_idx = SRC_W'(i);
            end
        end
    end

    always_comb begin
        grant_pld = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                grant_pld = bus.req_pld[i*PLD_WIDTH +: PLD_WIDTH];
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        accept  = found & can_load;
        if (accept) begin
            req_rdy[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d  = ST_FULL;
            rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (handoff) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            src_q    <= '0;
            pld_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                pld_q <= grant_pld;
                src_q <= grant_idx;
            end
            if (handoff) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.req_rdy   = req_rdy;
    assign bus.fp_vld    = fp_vld;
    assign bus.fp_pld    = pld_q;
    assign bus.fp_src_id = src_q;
    assign bus.issue_cnt = cnt_q;

    a_rdy_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_rdy));

    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (bus.fp_vld && !bus.fp_rdy) |=> ($stable(bus.fp_pld) && $stable(bus.fp_src_id)));
endmodule

// File: tb/tb_toy_fp_issue_arb.sv
// Directed bench for toy_fp_issue_arb: a 2-requester instance and a 3-requester
// instance sharing clock and reset.
module tb_toy_fp_issue_arb;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    toy_fp_issue_arb_if #(.NUM_REQ(2), .PLD_WIDTH(8)) b2 ();
    toy_fp_issue_arb_if #(.NUM_REQ(3), .PLD_WIDTH(8)) b3 ();

    toy_fp_issue_arb #(.NUM_REQ(2), .PLD_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    toy_fp_issue_arb #(.NUM_REQ(3), .PLD_WIDTH(8)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are checked 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        b2.req_vld = '0;
        b2.req_pld = '0;
        b2.flush   = 1'b0;
        b2.fp_rdy  = 1'b0;
        b3.req_vld = '0;
        b3.req_pld = '0;
        b3.flush   = 1'b0;
        b3.fp_rdy  = 1'b0;
        #22;
        rst_n = 1'b1;

        // Idle after reset
        b2.fp_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            #1;
            check("idle_fp_vld", 32'(b2.fp_vld), 0);
            check("idle_req_rdy", 32'(b2.req_rdy), 0);
            check("idle_cnt", 32'(b2.issue_cnt), 0);
        end
        check("idle_src", 32'(b2.fp_src_id), 0);
        check("idle_pld", 32'(b2.fp_pld), 0);

        // Both requesters valid, fp_rdy high: alternating grants, no bubbles
        next_cycle();
        b2.req_pld = 16'h2110;
        b2.req_vld = 2'b11;
        #1;
        check("rr_first_rdy", 32'(b2.req_rdy), 32'h1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k == 3) b2.req_vld = 2'b00;
            #1;
            check("rr_fp_vld", 32'(b2.fp_vld), 1);
            check("rr_src", 32'(b2.fp_src_id), 32'(k % 2));
            check("rr_pld", 32'(b2.fp_pld), (k % 2 == 0) ? 32'h10 : 32'h21);
            check("rr_cnt", 32'(b2.issue_cnt), 32'(k));
            check("rr_rdy", 32'(b2.req_rdy), (k == 3) ? 32'h0 : ((k % 2 == 0) ? 32'h2 : 32'h1));
        end
        next_cycle();
        #1;
        check("rr_cnt_final", 32'(b2.issue_cnt), 4);
        check("rr_drain_vld", 32'(b2.fp_vld), 0);

        // Only requester 1, FP unit busy for 3 cycles
        b2.req_pld = 16'hA5_00;
        b2.req_vld = 2'b10;
        b2.fp_rdy  = 1'b0;
        #1;
        check("hold_first_rdy", 32'(b2.req_rdy), 32'h2);
        for (int h = 0; h < 4; h++) begin
            next_cycle();
            if (h == 3) begin
                b2.req_vld = 2'b00;
                b2.fp_rdy  = 1'b1;
            end
            #1;
            check("hold_fp_vld", 32'(b2.fp_vld), 1);
            check("hold_pld", 32'(b2.fp_pld), 32'hA5);
            check("hold_src", 32'(b2.fp_src_id), 1);
            check("hold_rdy", 32'(b2.req_rdy), 0);
            check("hold_cnt", 32'(b2.issue_cnt), 4);
        end
        next_cycle();
        #1;
        check("hold_cnt_after", 32'(b2.issue_cnt), 5);
        check("hold_drain_vld", 32'(b2.fp_vld), 0);

        // Flush a staged op from requester 0 while the FP unit is busy
        b2.req_pld = 16'h2233;
        b2.req_vld = 2'b01;
        b2.fp_rdy  = 1'b0;
        next_cycle();
        b2.req_vld = 2'b00;
        #1;
        check("fl_staged_vld", 32'(b2.fp_vld), 1);
        check("fl_staged_src", 32'(b2.fp_src_id), 0);
        b2.flush   = 1'b1;
        b2.req_vld = 2'b11;
        #1;
        check("fl_vld_masked", 32'(b2.fp_vld), 0);
        check("fl_no_grant", 32'(b2.req_rdy), 0);
        next_cycle();
        b2.flush = 1'b0;
        #1;
        check("fl_vld_after", 32'(b2.fp_vld), 0);
        check("fl_cnt", 32'(b2.issue_cnt), 5);
        check("fl_rr_kept", 32'(b2.req_rdy), 32'h2);
        next_cycle();
        b2.req_vld = 2'b00;
        b2.fp_rdy  = 1'b1;
        #1;
        check("fl_regrant_src", 32'(b2.fp_src_id), 1);
        check("fl_regrant_pld", 32'(b2.fp_pld), 32'h22);
        next_cycle();
        #1;
        check("fl_cnt_after", 32'(b2.issue_cnt), 6);

        // Three requesters: pointer wraps from 2 back to 0
        b3.req_pld = 24'hC3_B2_A1;
        b3.fp_rdy  = 1'b1;
        b3.req_vld = 3'b010;
        #1;
        check("w3_rdy1", 32'(b3.req_rdy), 32'h2);
        next_cycle();
        b3.req_vld = 3'b101;
        #1;
        check("w3_src1", 32'(b3.fp_src_id), 1);
        check("w3_rdy2", 32'(b3.req_rdy), 32'h4);
        next_cycle();
        #1;
        check("w3_src2", 32'(b3.fp_src_id), 2);
        check("w3_pld2", 32'(b3.fp_pld), 32'hC3);
        check("w3_rdy0", 32'(b3.req_rdy), 32'h1);
        next_cycle();
        b3.req_vld = 3'b000;
        #1;
        check("w3_src0", 32'(b3.fp_src_id), 0);
        check("w3_pld0", 32'(b3.fp_pld), 32'hA1);
        next_cycle();
        #1;
        check("w3_cnt", 32'(b3.issue_cnt), 3);
        check("w3_drain_vld", 32'(b3.fp_vld), 0);

        // Asynchronous reset while the stage is full
        b2.req_pld = 16'h5544;
        b2.req_vld = 2'b01;
        b2.fp_rdy  = 1'b0;
        next_cycle();
        b2.req_vld = 2'b00;
        #1;
        check("rst_pre_vld", 32'(b2.fp_vld), 1);
        rst_n = 1'b0;
        #1;
        check("rst_fp_vld", 32'(b2.fp_vld), 0);
        check("rst_cnt", 32'(b2.issue_cnt), 0);
        check("rst_pld", 32'(b2.fp_pld), 0);
        check("rst_src", 32'(b2.fp_src_id), 0);
        next_cycle();
        rst_n      = 1'b1;
        b2.req_vld = 2'b11;
        b2.fp_rdy  = 1'b1;
        #1;
        check("rst_first_rdy", 32'(b2.req_rdy), 32'h1);
        next_cycle();
        b2.req_vld = 2'b00;
        #1;
        check("rst_first_src", 32'(b2.fp_src_id), 0);
        check("rst_first_pld", 32'(b2.fp_pld), 32'h44);
        check("rst_first_vld", 32'(b2.fp_vld), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/toy_fp_issue_arb.md
Name: toy_fp_issue_arb

Overview:
Round-robin arbiter that shares the single non-pipelined FP execution unit between NUM_REQ issue requesters (e.g. two FP issue queues). It picks one valid request per cycle into a one-entry staging register. The staged op drives the FP unit's valid/ready input handshake; the FP unit accepts one op, then deasserts ready for its FP_STAGES busy window. The arbiter also tags each issued op with its source id and counts issued ops.

Parameters:
NUM_REQ, 2, number of requesters (>=2).
PLD_WIDTH, $bits(eu_pkg), payload width per requester.
SRC_W, $clog2(NUM_REQ), source id width.
CNT_W, 16, issue counter width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_vld  input  NUM_REQ  per-requester op valid
req_rdy  output  NUM_REQ  per-requester accept (one-hot or zero)
req_pld  input  NUM_REQ*PLD_WIDTH  packed payloads; requester i at [i*PLD_WIDTH +: PLD_WIDTH]
flush  input  1  pipeline flush; cancels the staged op
fp_vld  output  1  staged op valid toward FP unit
fp_rdy  input  1  FP unit ready (high only when idle)
fp_pld  output  PLD_WIDTH  staged payload
fp_src_id  output  SRC_W  requester index of staged op
issue_cnt  output  CNT_W  count of ops handed to FP unit (fp_vld&fp_rdy)

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - stage_vld=0, so fp_vld=0.
  - fp_pld=0, fp_src_id=0, issue_cnt=0, rr_ptr=0.
  - req_rdy=0, since it is combinational and stage_vld=0 with nothing granted.
- Stage state:
  - EMPTY (stage_vld=0) or FULL (stage_vld=1).
  - handoff = fp_vld & fp_rdy.
  - can_load = ~flush & (~stage_vld | handoff).
- Arbitration (combinational):
  - Search req_vld starting at index rr_ptr and wrap modulo NUM_REQ; the first set bit wins, giving grant index g.
  - req_rdy[g] = can_load and a request exists; all other req_rdy bits are 0.
  - req_rdy[i] never asserts while req_vld[i]=0.
- On accept (req_vld[g]&req_rdy[g]):
  - Next cycle: stage_vld=1, fp_pld=req_pld[g], fp_src_id=g.
  - rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1.
- No accept:
  - If handoff, stage_vld <= 0; otherwise the stage holds.
  - rr_ptr is unchanged.
- Latency: accept in cycle t gives fp_vld=1 in cycle t+1. Back-to-back reload on handoff is allowed, so there is no bubble while fp_rdy stays high.
- Hold rule: while FULL and fp_rdy=0, fp_pld and fp_src_id are stable and req_rdy=0.
- fp_vld = stage_vld & ~flush.
- flush=1:
  - fp_vld is forced 0 in that cycle, so no handoff occurs.
  - stage_vld <= 0 next cycle.
  - No grant is made and rr_ptr is unchanged.
  - fp_pld keeps its old value (don't-care).
- issue_cnt increments by 1 on each handoff and wraps 2^CNT_W-1 -> 0. A flushed op is not counted.
- Reset mid-operation: the staged op is dropped immediately and asynchronously; all state returns to reset values.
- Simultaneous flush and handoff cannot occur, since fp_vld is masked by flush.
- Assertions:
  - $onehot0(req_rdy).
  - fp_vld stable-payload while ~fp_rdy.

Test Plan:
- Reset release, req_vld=2'b00 -> fp_vld=0, req_rdy=00, issue_cnt=0 for 5 cycles.
- req_vld=2'b11 held, fp_rdy=1 always -> grants alternate 0,1,0,1; fp_src_id sequence 0,1,0,1 from cycle t+1; issue_cnt=4 after 4 handoffs.
- Only req 1 valid with payload 0xA5, fp_rdy=0 for 3 cycles then 1 -> fp_vld high 4 cycles with fp_pld=0xA5, req_rdy=00 during hold, single handoff, issue_cnt=1.
- Stage FULL (src 0), fp_rdy=0, flush pulse 1 cycle -> fp_vld=0 that cycle and after, issue_cnt unchanged, rr_ptr still 1; next req 0+1 both valid -> req 1 granted.
- NUM_REQ=3, rr_ptr=2, req_vld=3'b101 -> grant 2, then rr_ptr wraps to 0 -> grant 0.
- Assert rst_n low while FULL -> fp_vld=0 asynchronously, issue_cnt=0; after release, first grant is req 0.
